dcache_mem_arbiter: RTL and testbench

//  Schedules the single DCache memory port among three requesters: write-buffer dirty-line

---
 rtl/dcache_mem_arbiter_pkg.sv | 22 ++
 rtl/dcache_arb_pick.sv | 59 +++++
 rtl/dcache_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_dcache_mem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_mem_arbiter_pkg.sv
// dcache_mem_arbiter_pkg: shared definitions for the DCache memory-port arbiter.
// Response source codes, FSM states, one-hot select bit positions, line/age widths.
package dcache_mem_arbiter_pkg;

  localparam int ARB_LINE_W = 256;
  localparam int ARB_AGE_W  = 4;

  localparam logic [1:0] SRC_WB = 2'd0;
  localparam logic [1:0] SRC_MR = 2'd1;
  localparam logic [1:0] SRC_UC = 2'd2;

  localparam int SEL_WB = 0;
  localparam int SEL_MR = 1;
  localparam int SEL_UC = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } arb_state_e;

endpackage

// File: rtl/dcache_arb_pick.sv
// dcache_arb_pick: combinational priority pick plus write-buffer age counter.
// Ports: clk_i/rst_i (sync, active-high), wb/mr/uc_req_i, wb/mr_tag_i (line tags),
// wb_grant_i (registered WB grant), sel_o (one-hot {UC,MR,WB}). Macro: DCACHE_ARB_AGE_EN.
module dcache_arb_pick
  import dcache_mem_arbiter_pkg::*;
#(
  parameter int TAG_W     = 27,
  parameter int AGE_LIMIT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wb_req_i,
  input  logic             mr_req_i,
  input  logic             uc_req_i,
  input  logic [TAG_W-1:0] wb_tag_i,
  input  logic [TAG_W-1:0] mr_tag_i,
  input  logic             wb_grant_i,
  output logic [2:0]       sel_o
);

  logic aged;
  logic same_line;

`ifdef DCACHE_ARB_AGE_EN
  localparam logic [ARB_AGE_W-1:0] LIM = ARB_AGE_W'(AGE_LIMIT);

  logic [ARB_AGE_W-1:0] age_q;
  logic [ARB_AGE_W-1:0] age_d;

  always_comb begin
    age_d = age_q;
    if (!wb_req_i || wb_grant_i) age_d = '0;
    else if (age_q != LIM) age_d = age_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) age_q <= '0;
    else       age_q <= age_d;
  end

  assign aged = wb_req_i && (age_q == LIM);
`else
  logic unused_age;
  assign unused_age = ^{clk_i, rst_i, wb_grant_i, 1'(AGE_LIMIT)};
  assign aged = 1'b0;
`endif

  // Dirty line must drain before its own refill reads stale memory.
  assign same_line = wb_req_i && mr_req_i && (wb_tag_i == mr_tag_i);

  always_comb begin
    sel_o = '0;
    if (aged || same_line) sel_o[SEL_WB] = 1'b1;
    else if (uc_req_i)     sel_o[SEL_UC] = 1'b1;
    else if (mr_req_i)     sel_o[SEL_MR] = 1'b1;
    else if (wb_req_i)     sel_o[SEL_WB] = 1'b1;
  end

endmodule

// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: one-outstanding arbiter of WB drain, MSHR refill and uncached ops
// onto the DCache memory port. Ports: Wb*/Mr*/Uc* requests + grants, Mem* request/response
// toward the AXI bridge, Resp* completion. Clk, Rest (sync, active-high). Macro: DCACHE_ARB_AGE_EN.
module dcache_mem_arbiter
  import dcache_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = ARB_LINE_W,
  parameter int PTR_W     = 3,
  parameter int AGE_LIMIT = 15
) (
  input  logic              Clk,
  input  logic              Rest,
  input  logic              WbReqAble,
  input  logic [ADDR_W-1:0] WbReqAddr,
  input  logic [LINE_W-1:0] WbReqDate,
  input  logic [PTR_W-1:0]  WbReqPtr,
  output logic              WbGrant,
  input  logic              MrReqAble,
  input  logic [ADDR_W-1:0] MrReqAddr,
  input  logic [PTR_W-1:0]  MrReqPtr,
  output logic              MrGrant,
  input  logic              UcReqAble,
  input  logic              UcReqWrite,
  input  logic [ADDR_W-1:0] UcReqAddr,
  input  logic [31:0]       UcReqDate,
  input  logic [3:0]        UcReqStrb,
  input  logic [PTR_W-1:0]  UcReqPtr,
  output logic              UcGrant,
  output logic              MemReqAble,
  output logic              MemReqWrite,
  output logic              MemUncache,
  output logic [ADDR_W-1:0] MemReqAddr,
  output logic [3:0]        MemReqStrb,
  output logic [LINE_W-1:0] MemWDate,
  input  logic              MemShankhand,
  input  logic              MemRespAble,
  input  logic [LINE_W-1:0] MemRespDate,
  output logic              RespAble,
  output logic [1:0]        RespSrc,
  output logic [PTR_W-1:0]  RespPtr,
  output logic [LINE_W-1:0] RespDate
);

  arb_state_e       state_q;
  logic [2:0]       sel;
  logic [1:0]       src_q;
  logic [PTR_W-1:0] ptr_q;

  dcache_arb_pick #(
    .TAG_W     (ADDR_W-5),
    .AGE_LIMIT (AGE_LIMIT)
  ) u_pick (
    .clk_i      (Clk),
    .rst_i      (Rest),
    .wb_req_i   (WbReqAble),
    .mr_req_i   (MrReqAble),
    .uc_req_i   (UcReqAble),
    .wb_tag_i   (WbReqAddr[ADDR_W-1:5]),
    .mr_tag_i   (MrReqAddr[ADDR_W-1:5]),
    .wb_grant_i (WbGrant),
    .sel_o      (sel)
  );

  always_ff @(posedge Clk) begin
    if (Rest) begin
      state_q     <= ST_IDLE;
      WbGrant     <= 1'b0;
      MrGrant     <= 1'b0;
      UcGrant     <= 1'b0;
      MemReqAble  <= 1'b0;
      MemReqWrite <= 1'b0;
      MemUncache  <= 1'b0;
      MemReqAddr  <= '0;
      MemReqStrb  <= '0;
      MemWDate    <= '0;
      RespAble    <= 1'b0;
      RespSrc     <= '0;
      RespPtr     <= '0;
      RespDate    <= '0;
      src_q       <= '0;
      ptr_q       <= '0;
    end else begin
      WbGrant  <= 1'b0;
      MrGrant  <= 1'b0;
      UcGrant  <= 1'b0;
      RespAble <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (|sel) begin
            state_q    <= ST_REQ;
            MemReqAble <= 1'b1;
            unique case (1'b1)
              sel[SEL_WB]: begin
                WbGrant     <= 1'b1;
                src_q       <= SRC_WB;
                ptr_q       <= WbReqPtr;
                MemReqWrite <= 1'b1;
                MemUncache  <= 1'b0;
                MemReqAddr  <= WbReqAddr;
                MemReqStrb  <= 4'hF;
                MemWDate    <= WbReqDate;
              end
              sel[SEL_MR]: begin
                MrGrant     <= 1'b1;
                src_q       <= SRC_MR;
                ptr_q       <= MrReqPtr;
                MemReqWrite <= 1'b0;
                MemUncache  <= 1'b0;
                MemReqAddr  <= MrReqAddr;
                MemReqStrb  <= 4'hF;
                MemWDate    <= '0;
              end
              sel[SEL_UC]: begin
                UcGrant     <= 1'b1;
                src_q       <= SRC_UC;
                ptr_q       <= UcReqPtr;
                MemReqWrite <= UcReqWrite;
                MemUncache  <= 1'b1;
                MemReqAddr  <= UcReqAddr;
                MemReqStrb  <= UcReqStrb;
                MemWDate    <= LINE_W'(UcReqDate);
              end
              default: ;
            endcase
          end
        end
        ST_REQ: begin
          if (MemShankhand) begin
            MemReqAble <= 1'b0;
            state_q    <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (MemRespAble) begin
            RespAble <= 1'b1;
            RespSrc  <= src_q;
            RespPtr  <= ptr_q;
            // Writes return no data; uncached reads carry one 32-bit beat.
            if (MemReqWrite)     RespDate <= '0;
            else if (MemUncache) RespDate <= LINE_W'(MemRespDate[31:0]);
            else                 RespDate <= MemRespDate;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb_dcache_mem_arbiter: table-driven grant-order vectors, directed corner sequences and
// randomized traffic checked cycle by cycle against a transaction-level reference model.
module tb_dcache_mem_arbiter;

  localparam int AW = 32;
  localparam int LW = 256;
  localparam int PW = 3;
  localparam int AGE_LIM = 15;

  logic          Clk = 1'b0;
  logic          Rest;
  logic          WbReqAble;
  logic [AW-1:0] WbReqAddr;
  logic [LW-1:0] WbReqDate;
  logic [PW-1:0] WbReqPtr;
  logic          WbGrant;
  logic          MrReqAble;
  logic [AW-1:0] MrReqAddr;
  logic [PW-1:0] MrReqPtr;
  logic          MrGrant;
  logic          UcReqAble;
  logic          UcReqWrite;
  logic [AW-1:0] UcReqAddr;
  logic [31:0]   UcReqDate;
  logic [3:0]    UcReqStrb;
  logic [PW-1:0] UcReqPtr;
  logic          UcGrant;
  logic          MemReqAble;
  logic          MemReqWrite;
  logic          MemUncache;
  logic [AW-1:0] MemReqAddr;
  logic [3:0]    MemReqStrb;
  logic [LW-1:0] MemWDate;
  logic          MemShankhand;
  logic          MemRespAble;
  logic [LW-1:0] MemRespDate;
  logic          RespAble;
  logic [1:0]    RespSrc;
  logic [PW-1:0] RespPtr;
  logic [LW-1:0] RespDate;

  always #5 Clk = ~Clk;

  dcache_mem_arbiter dut (
    .Clk(Clk), .Rest(Rest),
    .WbReqAble(WbReqAble), .WbReqAddr(WbReqAddr),
    .WbReqDate(WbReqDate), .WbReqPtr(WbReqPtr), .WbGrant(WbGrant),
    .MrReqAble(MrReqAble), .MrReqAddr(MrReqAddr),
    .MrReqPtr(MrReqPtr), .MrGrant(MrGrant),
    .UcReqAble(UcReqAble), .UcReqWrite(UcReqWrite),
    .UcReqAddr(UcReqAddr), .UcReqDate(UcReqDate),
    .UcReqStrb(UcReqStrb), .UcReqPtr(UcReqPtr), .UcGrant(UcGrant),
    .MemReqAble(MemReqAble), .MemReqWrite(MemReqWrite),
    .MemUncache(MemUncache), .MemReqAddr(MemReqAddr),
    .MemReqStrb(MemReqStrb), .MemWDate(MemWDate),
    .MemShankhand(MemShankhand), .MemRespAble(MemRespAble),
    .MemRespDate(MemRespDate),
    .RespAble(RespAble), .RespSrc(RespSrc),
    .RespPtr(RespPtr), .RespDate(RespDate)
  );

  int checks = 0;
  int errors = 0;

  // reference model state (transaction level)
  bit            m_busy, m_hs;
  logic [1:0]    m_src;
  logic [PW-1:0] m_ptr;
  logic          m_w, m_uc;
  logic [AW-1:0] m_a;
  logic [3:0]    m_s;
  logic [LW-1:0] m_wd;
  int            age;
  logic [2:0]    e_gnt, vis_gnt;
  bit            e_req, e_rsp;
  logic [1:0]    e_src;
  logic [PW-1:0] e_ptr;
  logic [LW-1:0] e_rdat;

  // stimulus control
  int hs_dly, rs_dly, wcnt;
  bit rnd, noise, uc_auto, force_rsp;
  int order[$];

  typedef struct {
    bit            wb, mr, uc;
    logic [AW-1:0] wa, ma;
    int            n;
    logic [5:0]    ord;
  } vec_t;

  vec_t tbl[6];

  task automatic chk(string nm, logic [LW-1:0] act, logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] d;
    for (int i = 0; i < LW/32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    return {20'h20000, 7'($urandom_range(0, 3)), 5'($urandom)};
  endfunction

  task automatic new_wb();
    WbReqAble = 1'b1;
    WbReqAddr = rand_addr();
    WbReqDate = rand_line();
    WbReqPtr  = PW'($urandom);
  endtask

  task automatic new_mr();
    MrReqAble = 1'b1;
    MrReqAddr = rand_addr();
    MrReqPtr  = PW'($urandom);
  endtask

  task automatic new_uc();
    UcReqAble  = 1'b1;
    UcReqWrite = 1'($urandom);
    UcReqAddr  = $urandom;
    UcReqDate  = $urandom;
    UcReqStrb  = 4'($urandom);
    UcReqPtr   = PW'($urandom);
  endtask

  function automatic int pick();
`ifdef DCACHE_ARB_AGE_EN
    if (WbReqAble && age == AGE_LIM) return 0;
`endif
    if (WbReqAble && MrReqAble &&
        WbReqAddr[AW-1:5] == MrReqAddr[AW-1:5]) return 0;
    if (UcReqAble) return 2;
    if (MrReqAble) return 1;
    return 0;
  endfunction

  // predict outputs after the next edge from the inputs of this cycle
  task automatic eval();
    int w;
    e_gnt = '0;
    e_rsp = 1'b0;
    if (!m_busy) begin
      if (WbReqAble || MrReqAble || UcReqAble) begin
        w = pick();
        e_gnt[w] = 1'b1;
        m_busy = 1'b1;
        m_hs = 1'b0;
        wcnt = 0;
        m_src = 2'(w);
        if (w == 0) begin
          m_ptr = WbReqPtr; m_w = 1'b1; m_uc = 1'b0;
          m_a = WbReqAddr; m_s = 4'hF; m_wd = WbReqDate;
        end else if (w == 1) begin
          m_ptr = MrReqPtr; m_w = 1'b0; m_uc = 1'b0;
          m_a = MrReqAddr; m_s = 4'hF; m_wd = '0;
        end else begin
          m_ptr = UcReqPtr; m_w = UcReqWrite; m_uc = 1'b1;
          m_a = UcReqAddr; m_s = UcReqStrb; m_wd = LW'(UcReqDate);
        end
        if (rnd) begin
          hs_dly = $urandom_range(0, 3);
          rs_dly = $urandom_range(0, 3);
        end
      end
    end else if (!m_hs) begin
      if (MemShankhand) begin
        m_hs = 1'b1;
        wcnt = 0;
      end
    end else if (MemRespAble) begin
      e_rsp = 1'b1;
      e_src = m_src;
      e_ptr = m_ptr;
      if (m_w) e_rdat = '0;
      else if (m_uc) e_rdat = LW'(MemRespDate[31:0]);
      else e_rdat = MemRespDate;
      m_busy = 1'b0;
      m_hs = 1'b0;
    end
`ifdef DCACHE_ARB_AGE_EN
    if (WbReqAble && !vis_gnt[0]) age = (age < AGE_LIM) ? age + 1 : AGE_LIM;
    else age = 0;
`endif
    e_req = m_busy && !m_hs;
  endtask

  task automatic check();
    chk("WbGrant", LW'(WbGrant), LW'(e_gnt[0]));
    chk("MrGrant", LW'(MrGrant), LW'(e_gnt[1]));
    chk("UcGrant", LW'(UcGrant), LW'(e_gnt[2]));
    chk("MemReqAble", LW'(MemReqAble), LW'(e_req));
    if (e_req) begin
      chk("MemReqWrite", LW'(MemReqWrite), LW'(m_w));
      chk("MemUncache", LW'(MemUncache), LW'(m_uc));
      chk("MemReqAddr", LW'(MemReqAddr), LW'(m_a));
      chk("MemReqStrb", LW'(MemReqStrb), LW'(m_s));
      chk("MemWDate", MemWDate, m_wd);
    end
    chk("RespAble", LW'(RespAble), LW'(e_rsp));
    if (e_rsp) begin
      chk("RespSrc", LW'(RespSrc), LW'(e_src));
      chk("RespPtr", LW'(RespPtr), LW'(e_ptr));
      chk("RespDate", RespDate, e_rdat);
    end
    if (WbGrant) order.push_back(0);
    if (MrGrant) order.push_back(1);
    if (UcGrant) order.push_back(2);
  endtask

  task automatic drive();
    if (vis_gnt[0]) WbReqAble = 1'b0;
    if (vis_gnt[1]) MrReqAble = 1'b0;
    if (vis_gnt[2]) begin
      if (uc_auto) new_uc();
      else UcReqAble = 1'b0;
    end
    if (rnd) begin
      if (!WbReqAble && $urandom_range(0, 5) == 0) new_wb();
      if (!MrReqAble && $urandom_range(0, 5) == 0) new_mr();
      if (!UcReqAble && $urandom_range(0, 7) == 0) new_uc();
    end
    MemShankhand = 1'b0;
    MemRespAble  = 1'b0;
    MemRespDate  = rand_line();
    if (m_busy && !m_hs) begin
      if (wcnt >= hs_dly) MemShankhand = 1'b1;
      else wcnt++;
      if (noise) MemRespAble = 1'($urandom);
    end else if (m_hs) begin
      if (wcnt >= rs_dly) MemRespAble = 1'b1;
      else wcnt++;
    end else begin
      if (noise) begin
        MemShankhand = 1'($urandom);
        MemRespAble  = 1'($urandom);
      end
      if (force_rsp) MemRespAble = 1'b1;
    end
  endtask

  task automatic tick();
    eval();
    @(posedge Clk);
    #1;
    check();
    vis_gnt = e_gnt;
    drive();
  endtask

  task automatic do_reset();
    Rest = 1'b1;
    WbReqAble = 1'b0; MrReqAble = 1'b0; UcReqAble = 1'b0;
    MemShankhand = 1'b0; MemRespAble = 1'b0;
    @(posedge Clk);
    #1;
    chk("rst_WbGrant", LW'(WbGrant), '0);
    chk("rst_MrGrant", LW'(MrGrant), '0);
    chk("rst_UcGrant", LW'(UcGrant), '0);
    chk("rst_MemReqAble", LW'(MemReqAble), '0);
    chk("rst_MemReqWrite", LW'(MemReqWrite), '0);
    chk("rst_MemUncache", LW'(MemUncache), '0);
    chk("rst_MemReqAddr", LW'(MemReqAddr), '0);
    chk("rst_MemReqStrb", LW'(MemReqStrb), '0);
    chk("rst_MemWDate", MemWDate, '0);
    chk("rst_RespAble", LW'(RespAble), '0);
    chk("rst_RespSrc", LW'(RespSrc), '0);
    chk("rst_RespPtr", LW'(RespPtr), '0);
    chk("rst_RespDate", RespDate, '0);
    m_busy = 1'b0; m_hs = 1'b0; age = 0; wcnt = 0;
    e_gnt = '0; vis_gnt = '0; e_req = 1'b0; e_rsp = 1'b0;
    Rest = 1'b0;
  endtask

  task automatic drain(int lim);
    int c = 0;
    while ((m_busy || WbReqAble || MrReqAble || UcReqAble) && c < lim) begin
      tick();
      c++;
    end
    if (c >= lim) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout cycles=%0d limit=%0d", c, lim);
    end
    tick();
    tick();
  endtask

  task automatic run_vec(int idx);
    order.delete();
    if (tbl[idx].wb) begin new_wb(); WbReqAddr = tbl[idx].wa; end
    if (tbl[idx].mr) begin new_mr(); MrReqAddr = tbl[idx].ma; MrReqPtr = 3'd3; end
    if (tbl[idx].uc) new_uc();
    drain(100);
    chk($sformatf("v%0d_len", idx), LW'(order.size()), LW'(tbl[idx].n));
    for (int i = 0; i < tbl[idx].n; i++)
      chk($sformatf("v%0d_ord%0d", idx, i),
          (i < order.size()) ? LW'(order[i]) : '1,
          LW'(tbl[idx].ord[2*i +: 2]));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit wb_seen;
    Rest = 1'b1;
    WbReqAble = 0; WbReqAddr = 0; WbReqDate = 0; WbReqPtr = 0;
    MrReqAble = 0; MrReqAddr = 0; MrReqPtr = 0;
    UcReqAble = 0; UcReqWrite = 0; UcReqAddr = 0;
    UcReqDate = 0; UcReqStrb = 0; UcReqPtr = 0;
    MemShankhand = 0; MemRespAble = 0; MemRespDate = 0;
    rnd = 0; noise = 0; uc_auto = 0; force_rsp = 0;
    hs_dly = 0; rs_dly = 1;
    do_reset();

    // orders are {third, second, first}; codes 0 WB, 1 MR, 2 UC
    tbl[0] = '{0, 1, 0, 32'h0, 32'h1000_0040, 1, {2'd0, 2'd0, 2'd1}};
    tbl[1] = '{1, 1, 1, 32'h3000_0000, 32'h3000_0100, 3, {2'd0, 2'd1, 2'd2}};
    tbl[2] = '{1, 1, 1, 32'h2000_0010, 32'h2000_0000, 3, {2'd1, 2'd2, 2'd0}};
    tbl[3] = '{1, 1, 0, 32'h4000_0020, 32'h4000_003C, 2, {2'd0, 2'd1, 2'd0}};
    tbl[4] = '{1, 0, 1, 32'h5000_0000, 32'h0, 2, {2'd0, 2'd0, 2'd2}};
    tbl[5] = '{1, 0, 0, 32'h6000_0040, 32'h0, 1, {2'd0, 2'd0, 2'd0}};
    for (int i = 0; i < 6; i++) run_vec(i);

    // address phase stalled 10 cycles with other requests waiting
    hs_dly = 10;
    new_mr();
    new_uc();
    drain(100);
    hs_dly = 0;

    // continuous uncached traffic against a waiting WB drain
    order.delete();
    uc_auto = 1;
    new_uc();
    new_wb();
    WbReqAddr = 32'h7000_0000;
    repeat (40) tick();
    wb_seen = 0;
    foreach (order[i]) if (order[i] == 0) wb_seen = 1;
`ifdef DCACHE_ARB_AGE_EN
    chk("age_wb_granted", LW'(wb_seen), LW'(1'b1));
`else
    chk("starve_wb_granted", LW'(wb_seen), LW'(1'b0));
`endif
    uc_auto = 0;
    drain(100);

    // reset while waiting for data, then a stray response
    rs_dly = 20;
    new_mr();
    for (int c = 0; c < 20 && !m_hs; c++) tick();
    tick();
    tick();
    do_reset();
    force_rsp = 1;
    repeat (4) tick();
    force_rsp = 0;
    rs_dly = 1;

    // randomized traffic with stray handshakes
    rnd = 1;
    noise = 1;
    repeat (3000) tick();
    rnd = 0;
    noise = 0;
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
